// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB with datapath strobes and selects.
// Latency with mem_ready_i=1: R/addi 4, lw 5, sw 4, beq 3, illegal 2 cycles; optional perf counters.
// Backpressure: mem_ready_i=0 holds FETCH or MEM indefinitely; ignored in other states. Option macro: MULTICYCLE_CTRL_PERF_EN.
module multicycle_controller (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [5:0]  op_i,
    input  logic        zero_i,
    input  logic        mem_ready_i,
    output logic        pc_write_o,
    output logic        ir_write_o,
    output logic        pc_branch_o,
    output logic        iord_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        alu_src_o,
    output logic        mem_to_reg_o,
    output logic        illegal_o,
    output logic [1:0]  alu_op_o,
    output logic [2:0]  state_o,
    output logic [31:0] instr_cnt_o,
    output logic [31:0] cycle_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;

    // Class of the latched opcode; only meaningful from EXEC onwards.
    logic is_r, is_addi, is_lw, is_sw, is_beq;
    // Legality of the live opcode, needed while it is still being latched in DECODE.
    logic op_i_legal;
    // Target of the next-instruction decision: stopping only happens between instructions.
    state_e next_instr;

    assign is_r    = (op_q == OP_RTYPE);
    assign is_addi = (op_q == OP_ADDI);
    assign is_lw   = (op_q == OP_LW);
    assign is_sw   = (op_q == OP_SW);
    assign is_beq  = (op_q == OP_BEQ);

    assign op_i_legal = (op_i == OP_RTYPE) || (op_i == OP_ADDI) || (op_i == OP_LW) ||
                        (op_i == OP_SW) || (op_i == OP_BEQ);

    assign next_instr = start_i ? S_FETCH : S_IDLE;
    assign state_o    = state_q;

    // State and opcode registers; synchronous reset overrides everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; op_q is captured on every DECODE cycle.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d    = op_i;
                state_d = op_i_legal ? S_EXEC : next_instr;
            end
            S_EXEC: begin
                if (is_beq)             state_d = next_instr;
                else if (is_lw || is_sw) state_d = S_MEM;
                else                    state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready_i) state_d = is_lw ? S_WB : next_instr;
            end
            S_WB: begin
                state_d = next_instr;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from state and latched opcode; FETCH strobes and the branch
    // strobe are additionally qualified by the memory ack and ALU zero flag.
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        pc_branch_o  = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        reg_dst_o    = 1'b0;
        alu_src_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        illegal_o    = 1'b0;
        alu_op_o     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read_o = 1'b1;
                pc_write_o = mem_ready_i;
                ir_write_o = mem_ready_i;
            end
            S_DECODE: begin
                illegal_o = ~op_i_legal;
            end
            S_EXEC: begin
                if (is_beq) begin
                    alu_op_o    = 2'b01;
                    pc_branch_o = zero_i;
                end else begin
                    alu_op_o  = is_r ? 2'b10 : 2'b00;
                    alu_src_o = is_addi || is_lw || is_sw;
                    reg_dst_o = is_r;
                end
            end
            S_MEM: begin
                iord_o      = 1'b1;
                mem_read_o  = is_lw;
                mem_write_o = is_sw;
                alu_op_o    = is_r ? 2'b10 : 2'b00;
                alu_src_o   = is_addi || is_lw || is_sw;
                reg_dst_o   = is_r;
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = is_lw;
                alu_op_o     = is_r ? 2'b10 : 2'b00;
                alu_src_o    = is_addi || is_lw || is_sw;
                reg_dst_o    = is_r;
            end
            default: ;
        endcase
    end

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] instr_cnt_q, instr_cnt_d;
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic        instr_done;

    // Counter update: busy cycles, and legal instructions leaving their final state.
    always_comb begin
        instr_done  = (state_q == S_WB) ||
                      (state_q == S_EXEC && is_beq) ||
                      (state_q == S_MEM && mem_ready_i && is_sw);
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (state_q != S_IDLE) cycle_cnt_d = cycle_cnt_q + 32'd1;
        if (instr_done)        instr_cnt_d = instr_cnt_q + 32'd1;
    end

    // Counter registers, cleared by reset and wrapping naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign instr_cnt_o = instr_cnt_q;
    assign cycle_cnt_o = cycle_cnt_q;
`else
    assign instr_cnt_o = 32'd0;
    assign cycle_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected output vectors are queued as stimulus is driven,
// a negedge monitor pops and compares them; counters are checked at fixed points.
// Expectations follow with/without MULTICYCLE_CTRL_PERF_EN.
module tb_multicycle_controller;

    logic        clk_i;
    logic        rst_i, start_i, zero_i, mem_ready_i;
    logic [5:0]  op_i;
    logic        pc_write_o, ir_write_o, pc_branch_o, iord_o, mem_read_o, mem_write_o;
    logic        reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o, illegal_o;
    logic [1:0]  alu_op_o;
    logic [2:0]  state_o;
    logic [31:0] instr_cnt_o, cycle_cnt_o;

`ifdef MULTICYCLE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_R = 6'b000000, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BAD = 6'b111111;

    // Output vector layout: {state[15:13], pcw, irw, pcb, iord, mr, mw, rw, rdst, asrc, m2r, ill, aluop[1:0]}
    localparam logic [15:0] S0 = 16'h0000, S1 = 16'h2000, S2 = 16'h4000;
    localparam logic [15:0] S3 = 16'h6000, S4 = 16'h8000, S5 = 16'hA000;
    localparam logic [15:0] SUB = 16'h0001, FN = 16'h0002, ILL = 16'h0004, M2R = 16'h0008;
    localparam logic [15:0] ASRC = 16'h0010, RDST = 16'h0020, RW = 16'h0040, MW = 16'h0080;
    localparam logic [15:0] MR = 16'h0100, IORD = 16'h0200, PCB = 16'h0400, IRW = 16'h0800;
    localparam logic [15:0] PCW = 16'h1000;
    localparam logic [15:0] F_OK = S1 | MR | PCW | IRW;

    logic [15:0] obs;
    assign obs = {state_o, pc_write_o, ir_write_o, pc_branch_o, iord_o, mem_read_o, mem_write_o,
                  reg_write_o, reg_dst_o, alu_src_o, mem_to_reg_o, illegal_o, alu_op_o};

    logic [15:0] exp_q[$];
    string       tag_q[$];
    int          total = 0;
    int          bad = 0;

    multicycle_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
        .pc_branch_o(pc_branch_o), .iord_o(iord_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
        .alu_src_o(alu_src_o), .mem_to_reg_o(mem_to_reg_o), .illegal_o(illegal_o),
        .alu_op_o(alu_op_o), .state_o(state_o), .instr_cnt_o(instr_cnt_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Drive one cycle of inputs (sampled at the next rising edge) and queue the outputs expected meanwhile.
    task automatic step(input string tag, input logic rst, input logic start, input logic [5:0] op,
                        input logic zero, input logic rdy, input logic [15:0] want);
        @(negedge clk_i);
        #1;
        rst_i = rst; start_i = start; op_i = op; zero_i = zero; mem_ready_i = rdy;
        exp_q.push_back(want);
        tag_q.push_back(tag);
    endtask

    // Scoreboard side: compare the DUT outputs for the cycle just driven.
    always @(negedge clk_i) begin
        logic [15:0] want;
        string       tag;
        #2;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            tag  = tag_q.pop_front();
            check(tag, {16'h0, obs}, {16'h0, want});
        end
    end

    task automatic check_cnt(input string tag, input int instr, input int cyc);
        #2;
        check({tag, "_instr"}, instr_cnt_o, PERF ? 32'(instr) : 32'd0);
        check({tag, "_cycle"}, cycle_cnt_o, PERF ? 32'(cyc) : 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; op_i = OP_R; zero_i = 1'b0; mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        // reset dominates start
        step("rst_prio",  1, 1, OP_R, 0, 1, S0);
        check_cnt("rst", 0, 0);
        step("idle_hold", 0, 0, OP_R, 0, 1, S0);
        step("idle_go",   0, 1, OP_R, 0, 1, S0);
        // R-type, memory always ready
        step("r_fetch",   0, 1, OP_R, 0, 1, F_OK);
        step("r_dec",     0, 1, OP_R, 0, 1, S2);
        step("r_exec",    0, 1, OP_R, 0, 1, S3 | FN | RDST);
        step("r_wb",      0, 1, OP_R, 0, 1, S5 | RW | FN | RDST);
        // lw with a fetch wait, ready low (ignored) in DECODE/EXEC, 3 MEM wait cycles
        step("lw_fwait",  0, 1, OP_R,  0, 0, S1 | MR);
        step("lw_fetch",  0, 1, OP_R,  0, 1, F_OK);
        step("lw_dec",    0, 1, OP_LW, 0, 0, S2);
        step("lw_exec",   0, 1, OP_R,  0, 0, S3 | ASRC);
        for (int i = 0; i < 3; i++)
            step("lw_mwait", 0, 1, OP_R, 0, 0, S4 | IORD | MR | ASRC);
        step("lw_mem",    0, 1, OP_R,  0, 1, S4 | IORD | MR | ASRC);
        step("lw_wb",     0, 1, OP_R,  0, 1, S5 | RW | M2R | ASRC);
        // beq taken then not taken
        step("beq1_f",    0, 1, OP_R,   0, 1, F_OK);
        step("beq1_d",    0, 1, OP_BEQ, 0, 1, S2);
        step("beq1_e",    0, 1, OP_R,   1, 1, S3 | SUB | PCB);
        step("beq0_f",    0, 1, OP_R,   1, 1, F_OK);
        step("beq0_d",    0, 1, OP_BEQ, 1, 1, S2);
        step("beq0_e",    0, 1, OP_R,   0, 1, S3 | SUB);
        // illegal opcode: one DECODE cycle then FETCH, no instruction counted
        step("ill_f",     0, 1, OP_R,   0, 1, F_OK);
        check_cnt("pre_ill", 4, 19);
        step("ill_d",     0, 1, OP_BAD, 0, 1, S2 | ILL);
        // addi
        step("addi_f",    0, 1, OP_R,    0, 1, F_OK);
        check_cnt("post_ill", 4, 21);
        step("addi_d",    0, 1, OP_ADDI, 0, 1, S2);
        step("addi_e",    0, 1, OP_R,    0, 1, S3 | ASRC);
        step("addi_wb",   0, 1, OP_R,    0, 1, S5 | RW | ASRC);
        // sw with start dropped in EXEC: must still complete MEM, then idle
        step("sw_f",      0, 1, OP_R,  0, 1, F_OK);
        step("sw_d",      0, 1, OP_SW, 0, 1, S2);
        step("sw_e",      0, 0, OP_R,  0, 1, S3 | ASRC);
        step("sw_mwait",  0, 0, OP_R,  0, 0, S4 | IORD | MW | ASRC);
        step("sw_mem",    0, 0, OP_R,  0, 1, S4 | IORD | MW | ASRC);
        step("sw_idle",   0, 0, OP_R,  0, 1, S0);
        check_cnt("prog", 6, 30);
        step("idle2",     0, 0, OP_R,  0, 1, S0);
        // reset in the middle of a lw MEM wait
        step("rm_go",     0, 1, OP_R,  0, 1, S0);
        step("rm_f",      0, 1, OP_R,  0, 1, F_OK);
        step("rm_d",      0, 1, OP_LW, 0, 1, S2);
        step("rm_e",      0, 1, OP_R,  0, 0, S3 | ASRC);
        step("rm_mem",    1, 1, OP_R,  0, 0, S4 | IORD | MR | ASRC);
        step("rm_after",  1, 1, OP_R,  0, 1, S0);
        check_cnt("rm", 0, 0);
        // three R-type instructions from reset, stopping after the third
        step("r3_go",     0, 1, OP_R, 0, 1, S0);
        for (int k = 0; k < 3; k++) begin
            step("r3_f", 0, 1, OP_R, 0, 1, F_OK);
            step("r3_d", 0, 1, OP_R, 0, 1, S2);
            step("r3_e", 0, (k != 2), OP_R, 0, 1, S3 | FN | RDST);
            step("r3_w", 0, (k != 2), OP_R, 0, 1, S5 | RW | FN | RDST);
        end
        step("r3_idle",   0, 0, OP_R, 0, 1, S0);
        check_cnt("r3", 3, 12);
        repeat (3) @(negedge clk_i);
        check("drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
